// File: rtl/f_le_responder.sv
// ---------------------------------------------------------------------------
// f_le_responder
//
// Responder side of the f_le compare interface. Accepts operand pairs on a
// valid/ready request channel, evaluates a <= b with IEEE-754 semantics in a
// two-stage pipeline, and returns {res, err, tag} in acceptance order through
// a buffered valid/ready response channel.
//
// Parameters
//   FLEN   operand width in bits
//   EXP_W  exponent field width (mantissa is FLEN-1-EXP_W bits)
//   TAG_W  width of the opaque tag echoed with each response
//   DEPTH  maximum number of in-flight requests and response FIFO depth
//
// Ports
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted (inflight < DEPTH)
//   req_a      operand a
//   req_b      operand b
//   req_tag    request tag
//   rsp_valid  response FIFO non-empty
//   rsp_ready  initiator consumes the head response
//   rsp_res    a <= b (forced 0 when rsp_err is set)
//   rsp_err    either operand is NaN
//   rsp_tag    tag of the head response
//   busy       at least one request is in flight
// ---------------------------------------------------------------------------
module f_le_responder #(
   parameter int FLEN  = 64,
   parameter int EXP_W = 11,
   parameter int TAG_W = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [FLEN-1:0]  req_a,
   input  logic [FLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_res,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int MAN_W  = FLEN - 1 - EXP_W;
   localparam int MAG_W  = FLEN - 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENTRY_W = TAG_W + 2;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   logic req_accept;
   logic fifo_pop;
   logic fifo_push;

   logic [CNT_W-1:0] inflight_reg;
   logic [CNT_W-1:0] inflight_next;
   logic [CNT_W-1:0] fifo_count_reg;
   logic [CNT_W-1:0] fifo_count_next;

   assign req_ready  = (inflight_reg < DEPTH_C);
   assign busy       = (inflight_reg != '0);
   assign rsp_valid  = (fifo_count_reg != '0);
   assign req_accept = req_valid && req_ready;
   assign fifo_pop   = rsp_valid && rsp_ready;

   // ------------------------------------------------------------------
   // Operand field decode (index 0 = a, index 1 = b)
   // ------------------------------------------------------------------
   logic [FLEN-1:0] op [2];
   logic [1:0]      op_nan;
   logic [1:0]      op_zero;
   logic [1:0]      op_sign;

   assign op[0] = req_a;
   assign op[1] = req_b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_decode
         logic [EXP_W-1:0] exp_f;
         logic [MAN_W-1:0] man_f;

         assign exp_f       = op[gi][FLEN-2 -: EXP_W];
         assign man_f       = op[gi][MAN_W-1:0];
         // All-ones exponent with a nonzero mantissa; infinities are not NaN.
         assign op_nan[gi]  = (&exp_f) && (|man_f);
         // Zero magnitude regardless of sign, so -0 and +0 both qualify.
         assign op_zero[gi] = ~(|op[gi][MAG_W-1:0]);
         assign op_sign[gi] = op[gi][FLEN-1];
      end
   endgenerate

   // {exp,man} ordered as an unsigned integer matches IEEE magnitude order,
   // including infinities.
   logic [MAG_W-1:0] mag_a;
   logic [MAG_W-1:0] mag_b;
   logic             mag_lt;
   logic             mag_eq;

   assign mag_a  = req_a[MAG_W-1:0];
   assign mag_b  = req_b[MAG_W-1:0];
   assign mag_lt = (mag_a < mag_b);
   assign mag_eq = (mag_a == mag_b);

   // ------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------
   logic             s1_valid_reg;
   logic             s1_nan_a_reg;
   logic             s1_nan_b_reg;
   logic             s1_both_zero_reg;
   logic             s1_sign_a_reg;
   logic             s1_sign_b_reg;
   logic             s1_mag_lt_reg;
   logic             s1_mag_eq_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg     <= 1'b0;
         s1_nan_a_reg     <= 1'b0;
         s1_nan_b_reg     <= 1'b0;
         s1_both_zero_reg <= 1'b0;
         s1_sign_a_reg    <= 1'b0;
         s1_sign_b_reg    <= 1'b0;
         s1_mag_lt_reg    <= 1'b0;
         s1_mag_eq_reg    <= 1'b0;
         s1_tag_reg       <= '0;
      end else begin
         s1_valid_reg <= req_accept;
         if (req_accept) begin
            s1_nan_a_reg     <= op_nan[0];
            s1_nan_b_reg     <= op_nan[1];
            s1_both_zero_reg <= op_zero[0] && op_zero[1];
            s1_sign_a_reg    <= op_sign[0];
            s1_sign_b_reg    <= op_sign[1];
            s1_mag_lt_reg    <= mag_lt;
            s1_mag_eq_reg    <= mag_eq;
            s1_tag_reg       <= req_tag;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: result resolution, written straight into the FIFO
   // ------------------------------------------------------------------
   logic s2_res;
   logic s2_err;

   always_comb begin
      s2_err = s1_nan_a_reg | s1_nan_b_reg;
      s2_res = 1'b0;
      if (!s2_err) begin
         if (s1_both_zero_reg) begin
            s2_res = 1'b1;
         end else if (s1_sign_a_reg != s1_sign_b_reg) begin
            // Differing signs: a <= b exactly when a is the negative one.
            s2_res = s1_sign_a_reg;
         end else if (!s1_sign_a_reg) begin
            s2_res = s1_mag_lt_reg | s1_mag_eq_reg;
         end else begin
            // Both negative: larger magnitude is the smaller value.
            s2_res = !s1_mag_lt_reg;
         end
      end
   end

   // The pipeline never stalls; credits bound the FIFO occupancy so a push
   // always has room and no full check is needed.
   assign fifo_push = s1_valid_reg;

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   logic [ENTRY_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [ENTRY_W-1:0] head_entry;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // Storage needs no reset: entries are only observed through rsp_valid.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr_reg] <= {s2_res, s2_err, s1_tag_reg};
      end
   end

   always_comb begin
      fifo_count_next = fifo_count_reg;
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
         2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
         default: fifo_count_next = fifo_count_reg;
      endcase
   end

   always_comb begin
      inflight_next = inflight_reg;
      case ({req_accept, fifo_pop})
         2'b10:   inflight_next = inflight_reg + CNT_W'(1);
         2'b01:   inflight_next = inflight_reg - CNT_W'(1);
         default: inflight_next = inflight_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         inflight_reg   <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (fifo_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         fifo_count_reg <= fifo_count_next;
         inflight_reg   <= inflight_next;
      end
   end

   // Head is read combinationally so an entry written at one edge is visible
   // in the very next cycle; the outputs are held at 0 whenever the FIFO is
   // empty so stale or uninitialised storage never leaks out.
   assign head_entry = fifo_mem[rd_ptr_reg];
   assign rsp_res    = rsp_valid ? head_entry[TAG_W+1] : 1'b0;
   assign rsp_err    = rsp_valid ? head_entry[TAG_W]   : 1'b0;
   assign rsp_tag    = rsp_valid ? head_entry[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_f_le_responder.sv
// ---------------------------------------------------------------------------
// tb_f_le_responder
//
// Directed testbench for f_le_responder. Every expected value below is
// hand-derived from the IEEE-754 operand encodings.
// ---------------------------------------------------------------------------
module tb_f_le_responder;

   localparam logic [63:0] ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] TWO  = 64'h4000000000000000;
   localparam logic [63:0] M1   = 64'hBFF0000000000000;
   localparam logic [63:0] M2   = 64'hC000000000000000;
   localparam logic [63:0] PZ   = 64'h0000000000000000;
   localparam logic [63:0] NZ   = 64'h8000000000000000;
   localparam logic [63:0] PINF = 64'h7FF0000000000000;
   localparam logic [63:0] NINF = 64'hFFF0000000000000;
   localparam logic [63:0] QNAN = 64'h7FF8000000000000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_res;
   logic        rsp_err;
   logic [1:0]  rsp_tag;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   f_le_responder #(
      .FLEN  (64),
      .EXP_W (11),
      .TAG_W (2),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_err   (rsp_err),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One isolated request with an empty FIFO: checks the 2-cycle latency,
   // the returned fields and the output gating once drained.
   task automatic single(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] tag, input logic exp_res, input logic exp_err);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      chk({name, "_req_ready"}, req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk({name, "_valid_early"}, rsp_valid, 0);
      tick();
      chk({name, "_valid"}, rsp_valid, 1);
      chk({name, "_res"}, rsp_res, exp_res);
      chk({name, "_err"}, rsp_err, exp_err);
      chk({name, "_tag"}, rsp_tag, tag);
      tick();
      chk({name, "_drained"}, rsp_valid, 0);
      chk({name, "_gated"}, {rsp_res, rsp_err, rsp_tag}, 0);
   endtask

   initial begin
      int idx;
      int got;
      logic acc;
      logic [1:0] exp_tag [6];
      logic       exp_res [6];

      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      rsp_ready = 1'b0;

      // ---------------- reset state ----------------
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      rst = 1'b0;
      tick();

      // ---------------- basic back-to-back compares ----------------
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_a = ONE; req_b = TWO; req_tag = 2'd1;
      tick();
      req_valid = 1'b1; req_a = TWO; req_b = ONE; req_tag = 2'd2;
      chk("basic_valid_early", rsp_valid, 0);
      chk("basic_busy", busy, 1);
      tick();
      req_valid = 1'b0;
      chk("basic1_valid", rsp_valid, 1);
      chk("basic1_res", rsp_res, 1);
      chk("basic1_err", rsp_err, 0);
      chk("basic1_tag", rsp_tag, 1);
      tick();
      chk("basic2_valid", rsp_valid, 1);
      chk("basic2_res", rsp_res, 0);
      chk("basic2_err", rsp_err, 0);
      chk("basic2_tag", rsp_tag, 2);
      tick();
      chk("basic_drained", rsp_valid, 0);
      chk("basic_idle", busy, 0);

      // ---------------- signed zeros, negatives, infinities ----------------
      single("nz_le_pz", NZ, PZ, 2'd0, 1'b1, 1'b0);
      single("pz_le_nz", PZ, NZ, 2'd1, 1'b1, 1'b0);
      single("m1_le_m2", M1, M2, 2'd2, 1'b0, 1'b0);
      single("m2_le_m1", M2, M1, 2'd3, 1'b1, 1'b0);
      single("ninf_le_pinf", NINF, PINF, 2'd0, 1'b1, 1'b0);
      single("pinf_le_ninf", PINF, NINF, 2'd1, 1'b0, 1'b0);
      single("one_le_one", ONE, ONE, 2'd2, 1'b1, 1'b0);

      // ---------------- NaN ----------------
      single("nan_a", QNAN, ONE, 2'd3, 1'b0, 1'b1);
      single("nan_b", ONE, QNAN, 2'd0, 1'b0, 1'b1);

      // ---------------- backpressure ----------------
      // Tags 0..5 truncate to 2 bits; even requests compare 1<=2, odd 2<=1.
      for (int i = 0; i < 6; i++) begin
         exp_tag[i] = 2'(i);
         exp_res[i] = (i % 2 == 0);
      end
      rsp_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         req_valid = 1'b1;
         req_tag   = exp_tag[idx];
         req_a     = (idx % 2 == 0) ? ONE : TWO;
         req_b     = (idx % 2 == 0) ? TWO : ONE;
         acc       = req_ready;
         tick();
         if (acc) idx++;
      end
      chk("bp_accepted", idx, 4);
      chk("bp_req_ready_low", req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_head_valid", rsp_valid, 1);
      chk("bp_head_tag", rsp_tag, 0);
      chk("bp_head_res", rsp_res, 1);
      tick();
      chk("bp_stable_tag", rsp_tag, 0);
      chk("bp_still_blocked", req_ready, 0);

      rsp_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         if (idx < 6) begin
            req_valid = 1'b1;
            req_tag   = exp_tag[idx];
            req_a     = (idx % 2 == 0) ? ONE : TWO;
            req_b     = (idx % 2 == 0) ? TWO : ONE;
         end else begin
            req_valid = 1'b0;
         end
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            chk($sformatf("bp_rsp%0d_tag", got), rsp_tag, exp_tag[got]);
            chk($sformatf("bp_rsp%0d_res", got), rsp_res, exp_res[got]);
            got++;
         end
         tick();
         if (acc) idx++;
         if (cyc == 0) chk("bp_ready_rise", req_ready, 1);
      end
      req_valid = 1'b0;
      chk("bp_all_accepted", idx, 6);
      chk("bp_all_drained", got, 6);
      tick();
      chk("bp_idle", busy, 0);

      // ---------------- simultaneous push/pop across pointer wrap ----------------
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_a = ONE; req_b = TWO; req_tag = 2'd0;
      tick();
      req_valid = 1'b1; req_a = TWO; req_b = ONE; req_tag = 2'd1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("pp_inflight_before", dut.inflight_reg, 2);
      chk("pp_head0_tag", rsp_tag, 0);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_a = M2; req_b = M1; req_tag = 2'd2;
      chk("pp_head0_res", rsp_res, 1);
      tick();
      chk("pp_inflight_1", dut.inflight_reg, 2);
      chk("pp_head1_tag", rsp_tag, 1);
      chk("pp_head1_res", rsp_res, 0);
      req_valid = 1'b1; req_a = M1; req_b = M2; req_tag = 2'd3;
      tick();
      req_valid = 1'b0;
      chk("pp_inflight_2", dut.inflight_reg, 2);
      chk("pp_head2_tag", rsp_tag, 2);
      chk("pp_head2_res", rsp_res, 1);
      tick();
      chk("pp_head3_valid", rsp_valid, 1);
      chk("pp_head3_tag", rsp_tag, 3);
      chk("pp_head3_res", rsp_res, 0);
      tick();
      chk("pp_drained", rsp_valid, 0);
      chk("pp_idle", busy, 0);

      // ---------------- asynchronous reset mid-operation ----------------
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_a = ONE; req_b = TWO; req_tag = 2'(i);
         tick();
      end
      req_valid = 1'b0;
      tick();
      chk("rm_pre_valid", rsp_valid, 1);
      chk("rm_pre_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rm_rsp_valid", rsp_valid, 0);
      chk("rm_busy", busy, 0);
      chk("rm_req_ready", req_ready, 1);
      chk("rm_tag_gated", rsp_tag, 0);
      #1;
      rst = 1'b0;
      tick();
      single("post_rst", TWO, ONE, 2'd3, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/f_le_responder.md
# f_le_responder

Pipelined floating-point less-or-equal compare service that answers requests from FSM-based initiators such as float sorters. It is the responder side of the `f_le` compare interface. It accepts operand pairs `a` and `b` through a valid/ready request channel and evaluates `a <= b` under IEEE-754 rules. Each result returns with its request tag through a valid/ready response channel, buffered so the initiator can apply backpressure.

## Interface
- `FLEN`, 64: operand width in bits.
- `EXP_W`, 11: exponent field width; mantissa width is `FLEN-1-EXP_W`.
- `TAG_W`, 2: width of the opaque request tag returned with each response.
- `DEPTH`, 4: maximum number of in-flight requests; also the response FIFO depth.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted; equals `inflight < DEPTH`.
- `req_a`  in  FLEN  operand a.
- `req_b`  in  FLEN  operand b.
- `req_tag`  in  TAG_W  request tag.
- `rsp_valid`  out  1  response FIFO is non-empty.
- `rsp_ready`  in  1  initiator consumes the head response.
- `rsp_res`  out  1  `a <= b`; 0 when `rsp_err` is 1.
- `rsp_err`  out  1  either operand is NaN.
- `rsp_tag`  out  TAG_W  tag of the head response.
- `busy`  out  1  `inflight != 0`.

## Operation
- **Acceptance.** A request is accepted on a rising edge where `req_valid && req_ready`. Responses are returned strictly in acceptance order.
- **Pipeline, stage 1.** Registered on acceptance. Holds:
  - `nan_a`, `nan_b`: exponent all ones and mantissa nonzero.
  - `zero_a && zero_b`: both magnitudes zero, sign ignored.
  - `sign_a`, `sign_b`.
  - Unsigned magnitude compares of `{exp,man}`: `mag_lt` and `mag_eq`.
  - Tag and a stage-valid bit.
- **Pipeline, stage 2.** Computes `res` and `err` from stage 1 and writes `{res, err, tag}` into the FIFO on the next edge if stage 1 is valid. The pipeline never stalls.
- **Result rules.**
  - `err = nan_a | nan_b`. When `err` is 1, `res = 0`.
  - Both operands zero: `res = 1`, so `-0 <= +0` and `+0 <= -0`.
  - Signs differ: `res = sign_a`.
  - Both positive: `res = mag_lt | mag_eq`.
  - Both negative: `res = !mag_lt`.
  - Infinities compare as ordinary values.
- **Credit counter.** `inflight` is `$clog2(DEPTH)+1` bits wide.
  - +1 on request accept; −1 on `rsp_valid && rsp_ready`.
  - Both events in the same cycle: unchanged.
  - The FIFO therefore can never overflow, so the FIFO has no full-write path.
- **Response FIFO.** Circular buffer of `DEPTH` entries with wrapping read and write pointers and an occupancy count.
  - Pop on `rsp_valid && rsp_ready`.
  - Simultaneous push and pop on a non-empty FIFO is legal; occupancy is unchanged.
  - `rsp_ready` while empty has no effect.
- **Output gating.** `rsp_res`, `rsp_err` and `rsp_tag` are driven to 0 while `rsp_valid` is 0.

## Timing
- **Reset values.** `rsp_valid=0`, `rsp_res=0`, `rsp_err=0`, `rsp_tag=0`, `busy=0`, `req_ready=1`.
- **Reset state.** `inflight=0`, stage-valid bits 0, FIFO pointers and occupancy 0.
- **Reset mid-operation.** Asserting `rst` at any time discards all in-flight and buffered responses immediately, without waiting for a clock edge.
- **Latency.** A request accepted at edge E0 enters stage 1 at E0 and is written to the FIFO at E1.
  - It appears on `rsp_*` in the cycle after E1, i.e. 2 cycles after the request cycle, when the FIFO was empty.
  - It appears later if older responses are queued ahead of it.
- **Throughput.** One request per cycle while `rsp_ready` is held 1.
- **Backpressure.** With `rsp_ready=0`, `req_ready` falls the cycle after the `DEPTH`-th outstanding accept. It rises the cycle after the first response is consumed.
- **Stability.** The `rsp_*` outputs are stable while `rsp_valid && !rsp_ready`.

## Test plan
- **Basic compares.** Send `a=3FF0000000000000 (1.0)`, `b=4000000000000000 (2.0)` with tag 1, then the swapped pair with tag 2, back-to-back, `rsp_ready=1`.
  - Required: `rsp_valid` 2 cycles after each request.
  - Responses: res=1/err=0/tag=1, then res=0/err=0/tag=2.
- **Signed zeros and negatives.**
  - `8000000000000000` vs `0000000000000000` → res=1.
  - `0000000000000000` vs `8000000000000000` → res=1.
  - `BFF0000000000000 (-1.0)` vs `C000000000000000 (-2.0)` → res=0.
  - `FFF0000000000000 (-inf)` vs `7FF0000000000000 (+inf)` → res=1.
- **NaN.** `a=7FF8000000000000` with `b=1.0`, then `b=7FF8000000000000` with `a=1.0`: each → err=1, res=0.
- **Backpressure.** Hold `rsp_ready=0` and issue 6 requests with tags 0..5.
  - Required: exactly 4 accepted; `req_ready=0` thereafter; `busy=1`.
  - Then raise `rsp_ready`: tags 0,1,2,3 drain in order.
  - The remaining 2 requests are accepted as credits return.
- **Simultaneous push/pop.** With 2 responses queued, accept a request in the same cycle a response is consumed: `inflight` is unchanged, and order is preserved across pointer wrap.
- **Reset mid-operation.** Assert `rst` asynchronously with 3 responses queued.
  - Required: `rsp_valid=0`, `busy=0` and `req_ready=1` immediately, before the next edge.
  - After release, one request responds cleanly at 2-cycle latency.
